// File: rtl/enc16to4_scan_if.sv
// ============================================================================
// Module : enc16to4_scan_if
// Brief  : Request/response bundle for the 16-to-4 scanning priority encoder.
//          The zero output exists only when ENC_ZERO_FLAG_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface enc16to4_scan_if;
    logic [0:15] w;
    logic        load;
    logic        ack;
    logic [3:0]  y;
    logic        valid;
    logic        busy;
    logic        done;
    logic [4:0]  count;
`ifdef ENC_ZERO_FLAG_EN
    logic        zero;
`endif

    modport master (
        output w, load, ack,
`ifdef ENC_ZERO_FLAG_EN
        input  zero,
`endif
        input  y, valid, busy, done, count
    );

    modport slave (
        input  w, load, ack,
`ifdef ENC_ZERO_FLAG_EN
        output zero,
`endif
        output y, valid, busy, done, count
    );
endinterface

`default_nettype wire

// File: rtl/enc16to4_scan.sv
// ============================================================================
// Module : enc16to4_scan
// Brief  : Captures a 16-bit request vector and emits the index of each set
//          bit in priority order (w[0] first), one per accepted ack.
//          Optional macro ENC_ZERO_FLAG_EN adds a zero-vector flag output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module enc16to4_scan (
    input  wire logic      clk,
    input  wire logic      rst,
    enc16to4_scan_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [0:15] r_p;
    logic [0:15] w_p_nxt;
    logic [0:15] w_p_clr;
    logic [4:0]  r_count;
    logic [4:0]  w_count_nxt;
    logic [4:0]  w_pop;
    logic [3:0]  w_idx;
    logic        w_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Scan downward so the lowest-numbered set bit is the final assignment.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_p[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_pop = w_pop + 5'(bus.w[i]);
        end
    end

    always_comb begin
        w_p_clr        = r_p;
        w_p_clr[w_idx] = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_p_nxt     = bus.w;
                    w_count_nxt = w_pop;
                    w_state_nxt = (bus.w != '0) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (bus.ack) begin
                    w_p_nxt     = w_p_clr;
                    w_state_nxt = (w_p_clr == '0) ? S_DONE : S_EMIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_valid   = (r_state == S_EMIT);
    assign bus.valid = w_valid;
    assign bus.y     = w_valid ? w_idx : 4'd0;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.count = r_count;

`ifdef ENC_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (r_state == S_IDLE && bus.load) begin
            r_zero <= (bus.w == '0);
        end
    end

    assign bus.zero = (r_state == S_DONE) && r_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_enc16to4_scan.sv
// ============================================================================
// Module : tb_enc16to4_scan
// Brief  : Self-checking bench: queue-based reference model checked every
//          cycle, a vector table, directed corner sequences and random traffic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_enc16to4_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;

    enc16to4_scan_if bus();

    enc16to4_scan dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending indices as a queue, mode 0=idle 1=emitting 2=done
    int mq[$];
    int mmode  = 0;
    int mcount = 0;
    bit mzw    = 1'b0;

    typedef struct {
        logic [0:15] w;
        int          cnt;
        int          first;
        int          last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic ld, input logic [0:15] wv, input logic ak);
        if (r) begin
            mmode = 0; mq.delete(); mcount = 0; mzw = 1'b0;
        end else begin
            case (mmode)
                0: if (ld) begin
                    mq.delete();
                    for (int k = 0; k < 16; k++) if (wv[k]) mq.push_back(k);
                    mcount = mq.size();
                    mzw    = (mq.size() == 0);
                    mmode  = (mq.size() != 0) ? 1 : 2;
                end
                1: if (ak) begin
                    void'(mq.pop_front());
                    mmode = (mq.size() != 0) ? 1 : 2;
                end
                default: mmode = 0;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(rst, bus.load, bus.w, bus.ack);
        #1;
        chk("model_valid", bus.valid, (mmode == 1));
        chk("model_y", bus.y, (mmode == 1) ? mq[0] : 0);
        chk("model_busy", bus.busy, (mmode != 0));
        chk("model_done", bus.done, (mmode == 2));
        chk("model_count", bus.count, mcount);
`ifdef ENC_ZERO_FLAG_EN
        chk("model_zero", bus.zero, (mmode == 2) && mzw);
`endif
    endtask

    vec_t tbl[6];
    logic [0:15] v;

    initial begin
        tbl[0] = '{16'h8000, 1, 0, 0};
        tbl[1] = '{16'h0001, 1, 15, 15};
        tbl[2] = '{16'hFFFF, 16, 0, 15};
        tbl[3] = '{16'h0180, 2, 7, 8};
        tbl[4] = '{16'h5555, 8, 1, 15};
        tbl[5] = '{16'h0000, 0, 0, 0};

        bus.w = '0; bus.load = 1'b0; bus.ack = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_busy", bus.busy, 0);
        chk("reset_valid", bus.valid, 0);
        chk("reset_count", bus.count, 0);
        rst = 1'b0;

        // Bits 2, 9, 15 drained with ack held high
        v = '0; v[2] = 1'b1; v[9] = 1'b1; v[15] = 1'b1;
        bus.w = v; bus.load = 1'b1; bus.ack = 1'b1;
        cycle();
        bus.load = 1'b0;
        chk("seq1_y0", bus.y, 2); chk("seq1_count", bus.count, 3);
        cycle(); chk("seq1_y1", bus.y, 9);
        cycle(); chk("seq1_y2", bus.y, 15); chk("seq1_v2", bus.valid, 1);
        cycle(); chk("seq1_done", bus.done, 1); chk("seq1_dvalid", bus.valid, 0);
        cycle(); chk("seq1_idle", bus.busy, 0);

        // Single bit held under backpressure
        v = '0; v[5] = 1'b1;
        bus.w = v; bus.load = 1'b1; bus.ack = 1'b0;
        cycle();
        bus.load = 1'b0;
        chk("seq2_y", bus.y, 5); chk("seq2_v", bus.valid, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("seq2_hold_y", bus.y, 5); chk("seq2_hold_v", bus.valid, 1);
        end
        bus.ack = 1'b1;
        cycle(); chk("seq2_done", bus.done, 1);
        bus.ack = 1'b0;
        cycle(); chk("seq2_idle", bus.busy, 0);

        // Empty vector goes straight to done
        bus.w = 16'h0000; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        chk("seq3_done", bus.done, 1); chk("seq3_valid", bus.valid, 0);
        chk("seq3_count", bus.count, 0); chk("seq3_busy", bus.busy, 1);
`ifdef ENC_ZERO_FLAG_EN
        chk("seq3_zero", bus.zero, 1);
`endif
        cycle(); chk("seq3_idle", bus.busy, 0);

        // Full vector with a second load mid-drain that must be ignored
        bus.w = 16'hFFFF; bus.load = 1'b1; bus.ack = 1'b1;
        cycle();
        chk("seq4_y0", bus.y, 0); chk("seq4_count", bus.count, 16);
        bus.w = 16'h0001;
        for (int i = 1; i < 16; i++) begin
            cycle();
            bus.load = 1'b0;
            chk("seq4_y", bus.y, i);
        end
        cycle(); chk("seq4_done", bus.done, 1); chk("seq4_count_d", bus.count, 16);
        cycle(); chk("seq4_idle", bus.busy, 0);

        // Reset mid-drain, then a fresh load
        bus.w = 16'h00F0; bus.load = 1'b1; bus.ack = 1'b1;
        cycle(); bus.load = 1'b0;
        chk("seq5_y0", bus.y, 8);
        cycle(); chk("seq5_y1", bus.y, 9);
        rst = 1'b1; bus.load = 1'b1;
        cycle();
        chk("seq5_rst_busy", bus.busy, 0); chk("seq5_rst_valid", bus.valid, 0);
        chk("seq5_rst_y", bus.y, 0); chk("seq5_rst_count", bus.count, 0);
        chk("seq5_rst_done", bus.done, 0);
        rst = 1'b0; bus.w = 16'h8000; bus.load = 1'b1;
        cycle(); bus.load = 1'b0;
        chk("seq5_new_y", bus.y, 0); chk("seq5_new_count", bus.count, 1);
        chk("seq5_new_valid", bus.valid, 1);
        cycle(); chk("seq5_new_done", bus.done, 1);
        cycle();

        // Vector table, ack held high throughout
        for (int t = 0; t < 6; t++) begin
            bus.w = tbl[t].w; bus.load = 1'b1; bus.ack = 1'b1;
            cycle();
            bus.load = 1'b0;
            chk("tbl_count", bus.count, tbl[t].cnt);
            if (tbl[t].cnt > 0) begin
                chk("tbl_first", bus.y, tbl[t].first);
                for (int i = 1; i < tbl[t].cnt; i++) cycle();
                chk("tbl_last", bus.y, tbl[t].last);
                cycle();
            end
            chk("tbl_done", bus.done, 1);
            cycle();
            chk("tbl_idle", bus.busy, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            bus.load = ($urandom_range(0, 2) == 0);
            bus.ack  = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       bus.w = 16'h0000;
                1:       bus.w = 16'(1 << $urandom_range(0, 15));
                default: bus.w = 16'($urandom);
            endcase
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/enc16to4_scan.md
ENC16TO4_SCAN -- requirements
Module: enc16to4_scan

Interface
REQ-001: Clock  input  1  rising-edge clock; the block's only clock.
REQ-002: Reset  input  1  synchronous, active-high reset.
REQ-003: W  input  [0:15]  request vector; W[0] is highest priority.
REQ-004: Load  input  1  capture W when idle.
REQ-005: Ack  input  1  consumer accepts the current index.
REQ-006: Y  output  [3:0]  encoded index of the current set bit (W[k] -> Y=k).
REQ-007: Valid  output  1  Y holds a valid index.
REQ-008: Busy  output  1  high in any state other than IDLE.
REQ-009: Done  output  1  one-cycle pulse when the captured vector is fully drained.
REQ-010: Count  output  [4:0]  number of set bits in the last captured vector.

Function
REQ-011: States SHALL be IDLE, EMIT and DONE, held in a state register clocked by Clock.
REQ-012: In IDLE with Load=1, the block SHALL capture W into pending register P and popcount(W) into Count; next state is EMIT if W!=0, else DONE.
REQ-013: Load SHALL be ignored in EMIT and DONE; Count and P SHALL be unaffected.
REQ-014: In EMIT, Valid=1 and Y = index of the lowest-numbered set bit of P; latency from Load edge to first Valid is 1 cycle.
REQ-015: Y and Valid SHALL stay stable while Valid=1 and Ack=0.
REQ-016: On Valid=1 and Ack=1, the emitted bit SHALL be cleared in P; if no other bit remains, next state is DONE, else EMIT with the next index on the following cycle.
REQ-017: Back-to-back Ack SHALL drain one index per cycle with no bubble.
REQ-018: Ack while Valid=0 SHALL be ignored.
REQ-019: DONE SHALL last exactly one cycle with Done=1, Valid=0, Busy=1, then go to IDLE.
REQ-020: Y SHALL read 4'd0 whenever Valid=0.
REQ-021: Count SHALL hold its value until the next accepted Load; W=16'hFFFF gives Count=16.

Reset
REQ-022: Reset=1 at a rising edge SHALL force IDLE, P=0, Count=0, Y=0, Valid=0, Busy=0, Done=0, including mid-drain.
REQ-023: Reset SHALL take priority over Load and Ack in the same cycle.

Configuration
REQ-024: Macro ENC_ZERO_FLAG_EN defined: extra output Zero (1 bit) SHALL be 1 during the DONE cycle only when the captured vector was 16'h0000, and 0 otherwise; Zero resets to 0.
REQ-025: Macro ENC_ZERO_FLAG_EN undefined: port Zero and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-026: Reset, then Load with W bits 2, 9, 15 set, Ack held at 1 -> Y = 2, 9, 15 on three consecutive cycles with Valid=1, Count=3, then Done pulse, then Busy=0.
REQ-027: Load with only W[5] set, Ack=0 for 4 cycles then 1 -> Y=5 and Valid=1 steady for 5 cycles, Done on the next cycle.
REQ-028: Load with W=16'h0000 -> no Valid, Done=1 on the cycle after Load, Count=0, Zero=1 when ENC_ZERO_FLAG_EN is defined.
REQ-029: Load with W=16'hFFFF, Ack=1 continuously, second Load pulse mid-drain with W=16'h0001 -> indices 0..15 in order, Count=16, second Load ignored.
REQ-030: Load with W=16'h00F0, Reset asserted after the first Ack -> next cycle all outputs 0 and state IDLE; a new Load is then accepted normally.
